// File: rtl/sys_defs.sv
// Shared sizing and types for the rename-stage physical register free list.
`ifndef PR_SIZE
`define PR_SIZE 64
`endif

package sys_defs;

    localparam int PR_SIZE   = `PR_SIZE;
    localparam int DISP_W    = 2;
    localparam int ARCH_REGS = 32;
    localparam int PR_IDX    = $clog2(PR_SIZE);
    localparam int CNT_W     = $clog2(PR_SIZE + 1);

    typedef logic [PR_IDX-1:0]  pr_idx_t;
    typedef logic [PR_SIZE-1:0] pr_vec_t;

    // PRs below ARCH_REGS hold the architectural mapping out of reset.
    localparam pr_vec_t ARCH_MASK  = (pr_vec_t'(1) << ARCH_REGS) - pr_vec_t'(1);
    localparam pr_vec_t RESET_FREE = ~ARCH_MASK;

    function automatic pr_vec_t onehot(input pr_idx_t idx);
        pr_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pr_popcnt.sv
// Population counter over a W-bit vector.
module pr_popcnt #(
    parameter int W  = 64,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/pr_free_list.sv
// Speculative and retirement free bitmaps for physical register renaming,
// with mispredict restore and a sticky protocol-error flag.
module pr_free_list
    import sys_defs::*;
(
    input  logic                      clock,
    input  logic                      reset,
    output logic [PR_SIZE-1:0]        free_vec,
    output logic [CNT_W-1:0]          free_cnt,
    output logic                      free_stall,
    input  logic [DISP_W-1:0]         alloc_en,
    input  logic [PR_SIZE*DISP_W-1:0] alloc_gnt_bus,
    input  logic [DISP_W-1:0]         rt_en,
    input  logic [DISP_W*PR_IDX-1:0]  rt_tnew,
    input  logic [DISP_W*PR_IDX-1:0]  rt_told,
    input  logic                      recover,
    output logic                      err
);

    localparam logic STALL_RST = (PR_SIZE - ARCH_REGS) < DISP_W;

    pr_vec_t          spec_q, spec_d;
    pr_vec_t          retire_q, retire_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;

    pr_vec_t          gnt [DISP_W];
    logic [CNT_W-1:0] gnt_cnt [DISP_W];

    pr_vec_t alloc_mask, free_mask, tnew_mask;
    logic    proto_err;
    pr_idx_t tnew_v, told_v;

    for (genvar g = 0; g < DISP_W; g++) begin : g_slot
        assign gnt[g] = alloc_gnt_bus[(g+1)*PR_SIZE-1 -: PR_SIZE];

        pr_popcnt #(.W(PR_SIZE), .CW(CNT_W)) u_gnt_cnt (
            .vec_i (gnt[g]),
            .cnt_o (gnt_cnt[g])
        );
    end

    // Overlap is detected against slots already folded into alloc_mask.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        tnew_mask  = '0;
        proto_err  = 1'b0;
        tnew_v     = '0;
        told_v     = '0;
        for (int i = 0; i < DISP_W; i++) begin
            if (alloc_en[i]) begin
                if (gnt_cnt[i] != CNT_W'(1))           proto_err = 1'b1;
                if ((gnt[i] & ~spec_q) != '0)          proto_err = 1'b1;
                if ((gnt[i] & alloc_mask) != '0)       proto_err = 1'b1;
                alloc_mask = alloc_mask | gnt[i];
            end
            if (rt_en[i]) begin
                tnew_v = rt_tnew[i*PR_IDX +: PR_IDX];
                told_v = rt_told[i*PR_IDX +: PR_IDX];
                if (retire_q[told_v])                  proto_err = 1'b1;
                if (retire_q[tnew_v])                  proto_err = 1'b1;
                if (tnew_v == told_v)                  proto_err = 1'b1;
                free_mask = free_mask | onehot(told_v);
                tnew_mask = tnew_mask | onehot(tnew_v);
            end
        end

        retire_d = (retire_q & ~tnew_mask) | free_mask;
        spec_d   = recover ? retire_d : ((spec_q & ~alloc_mask) | free_mask);
        err_d    = err_q | proto_err;
    end

    pr_popcnt #(.W(PR_SIZE), .CW(CNT_W)) u_free_cnt (
        .vec_i (spec_d),
        .cnt_o (cnt_d)
    );

    assign stall_d = cnt_d < CNT_W'(DISP_W);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spec_q   <= RESET_FREE;
            retire_q <= RESET_FREE;
            cnt_q    <= CNT_W'(PR_SIZE - ARCH_REGS);
            stall_q  <= STALL_RST;
            err_q    <= 1'b0;
        end else begin
            spec_q   <= spec_d;
            retire_q <= retire_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    assign free_vec   = spec_q;
    assign free_cnt   = cnt_q;
    assign free_stall = stall_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pr_free_list.sv
// Self-checking bench for pr_free_list: vector table, directed corner
// sequences and randomized traffic against a per-register reference model.
module tb_pr_free_list;
    import sys_defs::*;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [PR_SIZE-1:0]        free_vec;
    logic [CNT_W-1:0]          free_cnt;
    logic                      free_stall;
    logic [DISP_W-1:0]         alloc_en;
    logic [PR_SIZE*DISP_W-1:0] alloc_gnt_bus;
    logic [DISP_W-1:0]         rt_en;
    logic [DISP_W*PR_IDX-1:0]  rt_tnew;
    logic [DISP_W*PR_IDX-1:0]  rt_told;
    logic                      recover;
    logic                      err;

    always #5 clock = ~clock;

    pr_free_list dut (
        .clock         (clock),
        .reset         (reset),
        .free_vec      (free_vec),
        .free_cnt      (free_cnt),
        .free_stall    (free_stall),
        .alloc_en      (alloc_en),
        .alloc_gnt_bus (alloc_gnt_bus),
        .rt_en         (rt_en),
        .rt_tnew       (rt_tnew),
        .rt_told       (rt_told),
        .recover       (recover),
        .err           (err)
    );

    typedef struct {
        logic [1:0] aen;
        int         g0, x0, g1, x1;
        logic [1:0] ren;
        int         tn0, to0, tn1, to1;
        bit         rec;
    } stim_t;

    typedef struct {
        stim_t s;
        int    expCnt;
        bit    expStall;
        bit    expErr;
    } vec_t;

    int nCompared = 0;
    int nMismatch = 0;

    bit specFree [PR_SIZE];
    bit retFree  [PR_SIZE];
    bit errM;

    function automatic stim_t mk(input logic [1:0] aen, input int g0, input int g1,
                                 input logic [1:0] ren, input int tn0, input int to0,
                                 input int tn1, input int to1, input bit rec);
        stim_t s;
        s.aen = aen; s.g0 = g0; s.x0 = -1; s.g1 = g1; s.x1 = -1;
        s.ren = ren; s.tn0 = tn0; s.to0 = to0; s.tn1 = tn1; s.to1 = to1;
        s.rec = rec;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(2'b00, -1, -1, 2'b00, 0, 0, 0, 0, 1'b0);
    endfunction

    function automatic vec_t mkVec(input stim_t s, input int c, input bit st, input bit e);
        vec_t v;
        v.s = s; v.expCnt = c; v.expStall = st; v.expErr = e;
        return v;
    endfunction

    function automatic logic [63:0] modelVec();
        logic [63:0] v;
        v = '0;
        for (int p = 0; p < PR_SIZE; p++) v[p] = specFree[p];
        return v;
    endfunction

    function automatic int modelCnt();
        int c;
        c = 0;
        for (int p = 0; p < PR_SIZE; p++) c += int'(specFree[p]);
        return c;
    endfunction

    task automatic modelReset();
        for (int p = 0; p < PR_SIZE; p++) begin
            specFree[p] = (p >= ARCH_REGS);
            retFree[p]  = (p >= ARCH_REGS);
        end
        errM = 1'b0;
    endtask

    // Per-register view of one cycle: which PRs are taken, freed or committed.
    task automatic modelStep(input stim_t s);
        bit sl [2][PR_SIZE];
        bit freed [PR_SIZE];
        bit tnw [PR_SIZE];
        bit retNext [PR_SIZE];
        int g [2];
        int x [2];
        int tn [2];
        int to [2];
        int n;
        bit e;
        e = 1'b0;
        for (int p = 0; p < PR_SIZE; p++) begin
            sl[0][p] = 0; sl[1][p] = 0; freed[p] = 0; tnw[p] = 0;
        end
        g[0] = s.g0; g[1] = s.g1; x[0] = s.x0; x[1] = s.x1;
        tn[0] = s.tn0; tn[1] = s.tn1; to[0] = s.to0; to[1] = s.to1;
        for (int i = 0; i < 2; i++) begin
            if (s.aen[i]) begin
                n = 0;
                if (g[i] >= 0) begin n++; sl[i][g[i]] = 1; end
                if (x[i] >= 0 && x[i] != g[i]) begin n++; sl[i][x[i]] = 1; end
                if (n != 1) e = 1'b1;
                for (int p = 0; p < PR_SIZE; p++)
                    if (sl[i][p] && !specFree[p]) e = 1'b1;
            end
            if (s.ren[i]) begin
                if (retFree[to[i]] || retFree[tn[i]] || tn[i] == to[i]) e = 1'b1;
                freed[to[i]] = 1;
                tnw[tn[i]]   = 1;
            end
        end
        for (int p = 0; p < PR_SIZE; p++) if (sl[0][p] && sl[1][p]) e = 1'b1;
        for (int p = 0; p < PR_SIZE; p++) retNext[p] = freed[p] || (retFree[p] && !tnw[p]);
        for (int p = 0; p < PR_SIZE; p++) begin
            if (s.rec) specFree[p] = retNext[p];
            else       specFree[p] = freed[p] || (specFree[p] && !(sl[0][p] || sl[1][p]));
            retFree[p] = retNext[p];
        end
        errM = errM || e;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        alloc_en = '0; alloc_gnt_bus = '0; rt_en = '0;
        rt_tnew = '0; rt_told = '0; recover = 1'b0;
    endtask

    task automatic applyStimulus(input stim_t s);
        logic [PR_SIZE*DISP_W-1:0] bus;
        bus = '0;
        if (s.g0 >= 0) bus[s.g0] = 1'b1;
        if (s.x0 >= 0) bus[s.x0] = 1'b1;
        if (s.g1 >= 0) bus[PR_SIZE + s.g1] = 1'b1;
        if (s.x1 >= 0) bus[PR_SIZE + s.x1] = 1'b1;
        alloc_en      = s.aen;
        alloc_gnt_bus = bus;
        rt_en         = s.ren;
        rt_tnew       = {PR_IDX'(s.tn1), PR_IDX'(s.tn0)};
        rt_told       = {PR_IDX'(s.to1), PR_IDX'(s.to0)};
        recover       = s.rec;
        @(posedge clock);
        #1;
        modelStep(s);
        driveIdle();
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".vec"},   free_vec,   modelVec());
        checkVal({tag, ".cnt"},   64'(free_cnt), 64'(modelCnt()));
        checkVal({tag, ".stall"}, 64'(free_stall), 64'(modelCnt() < DISP_W));
        checkVal({tag, ".err"},   64'(err),   64'(errM));
    endtask

    task automatic doReset();
        reset = 1'b1;
        #3;
        modelReset();
        reset = 1'b0;
    endtask

    vec_t tbl [8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        int    freeQ[$];
        int    pool[$];
        int    k, r, gv, xv, tv, ov;

        driveIdle();
        reset = 1'b1;
        modelReset();
        #3 reset = 1'b0;

        tbl[0] = mkVec(idle(), 32, 0, 0);
        tbl[1] = mkVec(mk(2'b11, 32, 63, 2'b00, 0, 0, 0, 0, 0), 30, 0, 0);
        tbl[2] = mkVec(mk(2'b00, -1, -1, 2'b01, 1, 2, 0, 0, 0), 31, 0, 0);
        tbl[3] = mkVec(mk(2'b11, 33, 2, 2'b00, 0, 0, 0, 0, 0), 29, 0, 0);
        tbl[4] = mkVec(mk(2'b00, -1, -1, 2'b00, 0, 0, 0, 0, 1), 33, 0, 0);
        tbl[5] = mkVec(mk(2'b01, 40, -1, 2'b10, 0, 0, 3, 4, 0), 33, 0, 0);
        tbl[6] = mkVec(mk(2'b11, 50, 50, 2'b00, 0, 0, 0, 0, 0), 32, 0, 1);
        tbl[7] = mkVec(idle(), 32, 0, 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].s);
            checkVal($sformatf("tbl%0d.cnt", i),   64'(free_cnt),   64'(tbl[i].expCnt));
            checkVal($sformatf("tbl%0d.stall", i), 64'(free_stall), 64'(tbl[i].expStall));
            checkVal($sformatf("tbl%0d.err", i),   64'(err),        64'(tbl[i].expErr));
            checkVal($sformatf("tbl%0d.vec", i),   free_vec,        modelVec());
        end

        doReset();
        checkVal("rst.vec",   free_vec, 64'hFFFF_FFFF_0000_0000);
        checkVal("rst.cnt",   64'(free_cnt), 64'd32);
        checkVal("rst.stall", 64'(free_stall), 64'd0);
        checkVal("rst.err",   64'(err), 64'd0);

        applyStimulus(mk(2'b11, 32, 63, 2'b00, 0, 0, 0, 0, 0));
        checkVal("alloc2.vec", free_vec, 64'h7FFF_FFFE_0000_0000);
        checkVal("alloc2.cnt", 64'(free_cnt), 64'd30);
        applyStimulus(mk(2'b00, -1, -1, 2'b01, 32, 5, 0, 0, 0));
        checkVal("retire.bit5", 64'(free_vec[5]), 64'd1);
        checkVal("retire.cnt",  64'(free_cnt), 64'd31);
        checkVal("retire.err",  64'(err), 64'd1);

        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(2'b11, 33 + 2*i, 34 + 2*i, 2'b00, 0, 0, 0, 0, 0));
        checkVal("pre_rec.cnt", 64'(free_cnt), 64'd24);
        applyStimulus(mk(2'b00, -1, -1, 2'b01, 7, 6, 0, 0, 1));
        checkVal("recover.vec", free_vec, 64'hFFFF_FFFF_0000_0040);
        checkVal("recover.cnt", 64'(free_cnt), 64'd33);
        checkVal("recover.err", 64'(err), 64'd0);

        doReset();
        for (int i = 0; i < 15; i++)
            applyStimulus(mk(2'b11, 32 + 2*i, 33 + 2*i, 2'b00, 0, 0, 0, 0, 0));
        checkVal("two_left.cnt",   64'(free_cnt), 64'd2);
        checkVal("two_left.stall", 64'(free_stall), 64'd0);
        applyStimulus(mk(2'b01, 62, -1, 2'b00, 0, 0, 0, 0, 0));
        checkVal("one_left.cnt",   64'(free_cnt), 64'd1);
        checkVal("one_left.stall", 64'(free_stall), 64'd1);
        applyStimulus(mk(2'b00, -1, -1, 2'b01, 8, 7, 0, 0, 0));
        checkVal("unstall.cnt",   64'(free_cnt), 64'd2);
        checkVal("unstall.stall", 64'(free_stall), 64'd0);
        checkVal("unstall.err",   64'(err), 64'd0);

        doReset();
        applyStimulus(mk(2'b00, -1, -1, 2'b01, 9, 40, 0, 0, 0));
        checkVal("dblfree.err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idle());
            checkVal($sformatf("sticky%0d.err", i), 64'(err), 64'd1);
        end
        #2 reset = 1'b1;
        #1;
        checkVal("async_rst.err", 64'(err), 64'd0);
        checkVal("async_rst.vec", free_vec, 64'hFFFF_FFFF_0000_0000);
        checkVal("async_rst.cnt", 64'(free_cnt), 64'd32);
        reset = 1'b0;
        modelReset();

        doReset();
        applyStimulus(mk(2'b01, -1, -1, 2'b00, 0, 0, 0, 0, 0));
        checkVal("zero_gnt.err", 64'(err), 64'd1);
        checkVal("zero_gnt.cnt", 64'(free_cnt), 64'd32);

        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 50 == 49) doReset();
            s = idle();
            freeQ.delete();
            for (int p = 0; p < PR_SIZE; p++) if (specFree[p]) freeQ.push_back(p);
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 15);
                gv = -1; xv = -1;
                if (r < 10 && freeQ.size() > 0) begin
                    k = $urandom_range(0, freeQ.size() - 1);
                    gv = freeQ[k];
                    freeQ.delete(k);
                    s.aen[i] = 1'b1;
                end else if (r == 10) begin
                    s.aen[i] = 1'b1;
                end else if (r == 11) begin
                    gv = $urandom_range(0, PR_SIZE - 1);
                    s.aen[i] = 1'b1;
                end else if (r == 12) begin
                    gv = $urandom_range(0, PR_SIZE - 1);
                    xv = $urandom_range(0, PR_SIZE - 1);
                    s.aen[i] = 1'b1;
                end
                if (i == 0) begin s.g0 = gv; s.x0 = xv; end
                else        begin s.g1 = gv; s.x1 = xv; end
            end
            pool.delete();
            for (int p = 0; p < PR_SIZE; p++) if (!retFree[p]) pool.push_back(p);
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 15);
                tv = 0; ov = 0;
                if (r < 6 && pool.size() >= 2) begin
                    k = $urandom_range(0, pool.size() - 1);
                    tv = pool[k]; pool.delete(k);
                    k = $urandom_range(0, pool.size() - 1);
                    ov = pool[k]; pool.delete(k);
                    s.ren[i] = 1'b1;
                end else if (r == 6) begin
                    tv = $urandom_range(0, PR_SIZE - 1);
                    ov = $urandom_range(0, PR_SIZE - 1);
                    s.ren[i] = 1'b1;
                end
                if (i == 0) begin s.tn0 = tv; s.to0 = ov; end
                else        begin s.tn1 = tv; s.to1 = ov; end
            end
            s.rec = ($urandom_range(0, 11) == 0);
            applyStimulus(s);
            checkOutput($sformatf("rnd%0d", cyc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
